// File: rtl/input_port_ctrl_pkg.sv
// input_port_ctrl_pkg: MCU port map shared by the wrapper peripherals
package input_port_ctrl_pkg;
    typedef logic [7:0] port_id_t;
    localparam port_id_t SW_ID     = 8'h20;
    localparam port_id_t STATUS_ID = 8'h21;
    localparam port_id_t MASK_ID   = 8'h22;
    localparam port_id_t LEDS_ID   = 8'h40;
    localparam port_id_t CLR_ID    = 8'h41;
endpackage

// File: rtl/input_port_ctrl_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stability counter for one switch
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, done;
    logic [CW-1:0] cnt;
    // rise is asserted during the cycle whose edge flips stable 0->1
    assign done = (s2 != stable) && (cnt == LAST);
    assign rise = done && s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            cnt    <= (s2 == stable || done) ? '0 : cnt + CW'(1);
            stable <= done ? s2 : stable;
        end
    end
endmodule

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: debounced switch port with rising-edge flags, mask and interrupt
module input_port_ctrl
    import input_port_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SWITCHES,
    input  logic [7:0]       PORT_ID,
    input  logic [WIDTH-1:0] OUT_PORT,
    input  logic             IO_STRB,
    output logic [WIDTH-1:0] IN_PORT,
    output logic             INTR
);
    logic [WIDTH-1:0] stable, rise, evt, mask, clr;
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(CLK), .rst(RESET), .raw(SWITCHES[i]), .stable(stable[i]), .rise(rise[i])
        );
    end
    always_comb begin
        clr = (IO_STRB && PORT_ID == CLR_ID) ? OUT_PORT : '0;
        IN_PORT = (PORT_ID == SW_ID)     ? stable :
                  (PORT_ID == STATUS_ID) ? evt    :
                  (PORT_ID == MASK_ID)   ? mask   : '0;
    end
    // a new rise is ORed in after the clear so set wins on collision
    always_ff @(posedge CLK) begin
        if (RESET) begin
            evt  <= '0;
            mask <= '0;
            INTR <= 1'b0;
        end else begin
            evt  <= (evt & ~clr) | rise;
            mask <= (IO_STRB && PORT_ID == MASK_ID) ? OUT_PORT : mask;
            INTR <= |(evt & mask);
        end
    end
endmodule

// File: tb/tb_input_port_ctrl.sv
// tb_input_port_ctrl: directed checks of debounce, flags, mask, clear and interrupt
module tb_input_port_ctrl;
    import input_port_ctrl_pkg::*;
    logic CLK = 1'b0, RESET, IO_STRB, INTR;
    logic [7:0] SWITCHES, PORT_ID, OUT_PORT, IN_PORT;
    int tests = 0, fails = 0;

    input_port_ctrl #(.DEBOUNCE_CYCLES(4), .WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .SWITCHES(SWITCHES), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTR(INTR)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
        PORT_ID = id;
        #1;
        check(tag, IN_PORT, exp);
    endtask

    task automatic chk_intr(input string tag, input logic exp);
        check(tag, {7'b0, INTR}, {7'b0, exp});
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID = id;
        OUT_PORT = d;
        IO_STRB = 1'b1;
        tick();
        IO_STRB = 1'b0;
        OUT_PORT = 8'h00;
    endtask

    initial begin
        RESET = 1'b1; SWITCHES = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
        repeat (3) tick();
        chk_rd("rst_sw", SW_ID, 8'h00);
        chk_rd("rst_status", STATUS_ID, 8'h00);
        chk_rd("rst_mask", MASK_ID, 8'h00);
        chk_intr("rst_intr", 1'b0);
        RESET = 1'b0;
        repeat (2) tick();
        SWITCHES = 8'h05;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk_rd("lat_sw_early", SW_ID, 8'h00);
        end
        tick();
        chk_rd("lat_sw", SW_ID, 8'h05);
        chk_rd("lat_status", STATUS_ID, 8'h05);
        chk_rd("other_id", LEDS_ID, 8'h00);
        chk_intr("masked_intr", 1'b0);
        wr(CLR_ID, 8'hFF);
        chk_rd("clr_all", STATUS_ID, 8'h00);

        SWITCHES = 8'h0D;
        repeat (3) tick();
        SWITCHES = 8'h05;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk_rd("glitch_sw", SW_ID, 8'h05);
            chk_rd("glitch_status", STATUS_ID, 8'h00);
        end
        SWITCHES = 8'h0D;
        repeat (4) tick();
        SWITCHES = 8'h05;
        repeat (2) tick();
        chk_rd("pulse4_sw", SW_ID, 8'h0D);
        chk_rd("pulse4_status", STATUS_ID, 8'h08);
        repeat (4) tick();
        chk_rd("fall_sw", SW_ID, 8'h05);
        chk_rd("fall_status", STATUS_ID, 8'h08);
        wr(CLR_ID, 8'hFF);

        wr(MASK_ID, 8'h01);
        chk_rd("mask_rd", MASK_ID, 8'h01);
        chk_intr("mask_only_intr", 1'b0);
        SWITCHES = 8'h00;
        repeat (8) tick();
        chk_rd("fall_no_flag", STATUS_ID, 8'h00);
        SWITCHES = 8'h02;
        repeat (6) tick();
        chk_rd("bit1_status", STATUS_ID, 8'h02);
        tick();
        chk_intr("bit1_intr_low", 1'b0);
        SWITCHES = 8'h03;
        repeat (6) tick();
        chk_rd("bit0_status", STATUS_ID, 8'h03);
        chk_intr("bit0_intr_same", 1'b0);
        tick();
        chk_intr("bit0_intr_next", 1'b1);

        wr(CLR_ID, 8'h01);
        chk_rd("clr_status", STATUS_ID, 8'h02);
        chk_intr("clr_intr_hold", 1'b1);
        tick();
        chk_intr("clr_intr_drop", 1'b0);

        SWITCHES = 8'h07;
        repeat (5) tick();
        wr(CLR_ID, 8'h04);
        chk_rd("collide_status", STATUS_ID, 8'h06);
        wr(CLR_ID, 8'h04);
        chk_rd("clr_bit2", STATUS_ID, 8'h02);

        SWITCHES = 8'h00;
        repeat (8) tick();
        SWITCHES = 8'hFF;
        repeat (6) tick();
        chk_rd("all_status", STATUS_ID, 8'hFF);
        tick();
        chk_intr("all_intr", 1'b1);
        SWITCHES = 8'hFE;
        repeat (4) tick();
        RESET = 1'b1;
        SWITCHES = 8'h01;
        tick();
        chk_rd("mid_rst_sw", SW_ID, 8'h00);
        chk_rd("mid_rst_status", STATUS_ID, 8'h00);
        chk_rd("mid_rst_mask", MASK_ID, 8'h00);
        chk_intr("mid_rst_intr", 1'b0);
        RESET = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk_rd("rel_status_early", STATUS_ID, 8'h00);
        end
        tick();
        chk_rd("rel_status", STATUS_ID, 8'h01);
        chk_rd("rel_sw", SW_ID, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
